// File: rtl/ysyx_040066_bp_pkg.sv
// Shared types and helpers for the fetch next-PC branch predictor.
package ysyx_040066_bp_pkg;

    // Storage width for tags and targets; the top's XLEN must not exceed it.
    localparam int unsigned BP_XLEN = 64;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        logic               uncond;
        logic [1:0]         ctr;
    } btb_entry_t;

    localparam btb_entry_t ENTRY_RST = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        uncond: 1'b0,
        ctr:    CTR_WEAK_NT
    };

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/ysyx_040066_bp_table.sv
// Direct-mapped BTB storage: two async read ports (fetch, EX), one write port,
// whole array cleared by the asynchronous reset.
module ysyx_040066_bp_table
    import ysyx_040066_bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] i_rd_idx_f,
    output btb_entry_t      o_rd_ent_f,
    input  logic [IDXW-1:0] i_rd_idx_ex,
    output btb_entry_t      o_rd_ent_ex,
    input  logic            i_wr_en,
    input  logic [IDXW-1:0] i_wr_idx,
    input  btb_entry_t      i_wr_ent
);

    btb_entry_t r_tab [ENTRIES];

    // Reads are pre-edge contents; a same-cycle write is not bypassed.
    always_comb begin
        o_rd_ent_f  = r_tab[i_rd_idx_f];
        o_rd_ent_ex = r_tab[i_rd_idx_ex];
    end

    // Single write port; async reset invalidates every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tab[i] <= ENTRY_RST;
            end
        end else if (i_wr_en) begin
            r_tab[i_wr_idx] <= i_wr_ent;
        end
    end

endmodule

// File: rtl/ysyx_040066_nxtpc_bp.sv
// Fetch next-PC generator with BTB + 2-bit counters, EX mispredict recovery and training.
// Optional build macro YSYX_040066_BP_STATS_EN adds stat_branches / stat_mispred counters.
module ysyx_040066_nxtpc_bp
    import ysyx_040066_bp_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_ready,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_jmp,
    input  logic            ex_uncond,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush
`ifdef YSYX_040066_BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int unsigned IDXW = $clog2(ENTRIES);

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    w_pc_d;
    logic [IDXW-1:0]    w_f_idx;
    logic [IDXW-1:0]    w_ex_idx;
    logic [BP_XLEN-1:0] w_f_tag;
    logic [BP_XLEN-1:0] w_ex_tag;
    btb_entry_t         w_f_ent;
    btb_entry_t         w_ex_ent;
    btb_entry_t         w_wr_ent;
    logic               w_wr_en;
    logic               w_f_hit;
    logic               w_ex_hit;
    logic               w_mispred;
    logic [XLEN-1:0]    w_pc_inc;
    logic [XLEN-1:0]    w_ex_inc;
    logic [XLEN-1:0]    w_fix_pc;
    logic               w_unused;

    assign w_f_idx  = r_pc[IDXW+1:2];
    assign w_ex_idx = ex_pc[IDXW+1:2];
    assign w_f_tag  = BP_XLEN'(r_pc >> (IDXW + 2));
    assign w_ex_tag = BP_XLEN'(ex_pc >> (IDXW + 2));
    assign w_pc_inc = r_pc + XLEN'(4);
    assign w_ex_inc = ex_pc + XLEN'(4);
    // Fetch port ignores the counter LSB; EX port's old uncond is always overwritten.
    assign w_unused = w_f_ent.ctr[0] ^ w_ex_ent.uncond;

    ysyx_040066_bp_table #(
        .ENTRIES (ENTRIES),
        .IDXW    (IDXW)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx_f  (w_f_idx),
        .o_rd_ent_f  (w_f_ent),
        .i_rd_idx_ex (w_ex_idx),
        .o_rd_ent_ex (w_ex_ent),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_ex_idx),
        .i_wr_ent    (w_wr_ent)
    );

    // Fetch-side lookup and prediction.
    always_comb begin
        w_f_hit     = w_f_ent.valid && (w_f_ent.tag == w_f_tag);
        pred_taken  = w_f_hit && (w_f_ent.uncond || w_f_ent.ctr[1]);
        pred_target = pred_taken ? XLEN'(w_f_ent.target) : w_pc_inc;
    end

    // Mispredict detection; a non-jump predicted taken is a stale alias.
    always_comb begin
        w_mispred = 1'b0;
        if (ex_valid) begin
            if (ex_is_jmp) begin
                w_mispred = (ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_target != ex_pred_target));
            end else begin
                w_mispred = ex_pred_taken;
            end
        end
        w_fix_pc = (ex_is_jmp && ex_taken) ? ex_target : w_ex_inc;
        flush    = w_mispred;
    end

    // Next-PC priority: recovery, then advance, then hold.
    always_comb begin
        if (w_mispred) begin
            w_pc_d = w_fix_pc;
        end else if (if_ready) begin
            w_pc_d = pred_target;
        end else begin
            w_pc_d = r_pc;
        end
    end

    // Table update from resolved EX instruction.
    always_comb begin
        w_ex_hit = w_ex_ent.valid && (w_ex_ent.tag == w_ex_tag);
        w_wr_en  = 1'b0;
        w_wr_ent = w_ex_ent;
        if (ex_valid && ex_is_jmp) begin
            if (w_ex_hit) begin
                w_wr_en         = 1'b1;
                w_wr_ent.ctr    = ex_taken ? ctr_sat_inc(w_ex_ent.ctr) : ctr_sat_dec(w_ex_ent.ctr);
                w_wr_ent.uncond = ex_uncond;
                if (ex_taken) begin
                    w_wr_ent.target = BP_XLEN'(ex_target);
                end
            end else if (ex_taken) begin
                w_wr_en  = 1'b1;
                w_wr_ent = '{
                    valid:  1'b1,
                    tag:    w_ex_tag,
                    target: BP_XLEN'(ex_target),
                    uncond: ex_uncond,
                    ctr:    CTR_WEAK_T
                };
            end
        end else if (ex_valid && w_ex_hit) begin
            w_wr_en        = 1'b1;
            w_wr_ent.valid = 1'b0;
        end
    end

    // Architectural fetch PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_d;
        end
    end

    assign pc = r_pc;

`ifdef YSYX_040066_BP_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mp;

    // Free-running event counters, wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else begin
            if (ex_valid && ex_is_jmp) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (w_mispred) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_mispred  = r_stat_mp;
`endif

endmodule
